register_bus_scheduler: RTL and testbench
=========================================

# register_bus_scheduler

Sequences and shares a bank of `REGISTER_FLIP_FLOP`-style registers between two requesters: port A (CPU core) and port B (display/scan logic). Each register has a clock-enable, a tick and a tri-state output with active-high `cs` that forces high-Z. The scheduler owns all of them: one-hot write enables, the shared `D` bus, per-register `cs`, and capture of the shared read bus. It sits between the CPU/display front ends and the register bank.

## Interface
- `NrOfRegs`, 8, number of registers in the bank (2..16)
- `NrOfBits`, 8, register data width
- `AddrBits`, 4, requester address width; must satisfy 2^AddrBits ≥ NrOfRegs
- `Clock` in 1: the single clock. All state changes on its rising edge.
- `Reset` in 1: synchronous, **active-low** reset, sampled on the rising edge of `Clock`.
- `a_req`, `b_req` in 1: transaction request, held until the matching `*_gnt`
- `a_we`, `b_we` in 1: 1 = write, 0 = read
- `a_addr`, `b_addr` in AddrBits: register index
- `a_wdata`, `b_wdata` in NrOfBits: write data
- `a_gnt`, `b_gnt` out 1: one-cycle acceptance pulse
- `a_rvalid`, `b_rvalid` out 1: one-cycle read-data-valid pulse
- `a_rdata`, `b_rdata` out NrOfBits: read data, held until the next read on that port
- `bank_ce` out NrOfRegs: one-hot `ClockEnable` per register
- `bank_tick` out 1: shared `Tick`
- `bank_d` out NrOfBits: shared `D` bus
- `bank_cs` out NrOfRegs: per-register `cs`; 1 = high-Z, 0 = drive bus
- `bank_q` in NrOfBits: shared tri-state read bus
- `bank_clear` out 1: drives the bank's async `Reset`

## Operation
- States:
  - IDLE: arbitrate. If no request, stay in IDLE. If the winner has `we`=1, go to WRITE; if `we`=0, go to RD_DRIVE.
  - WRITE: latched port's `gnt`=1, `bank_ce[addr]`=1, `bank_tick`=1, `bank_d`=latched wdata; then IDLE.
  - RD_DRIVE: `gnt`=1, `bank_cs[addr]`=0 (bus settle); then RD_CAPTURE.
  - RD_CAPTURE: `bank_cs[addr]`=0, `bank_q` registered into the port's `rdata`; then RD_DONE.
  - RD_DONE: `rvalid`=1 for one cycle, all `bank_cs`=1; then IDLE.
- Winner's `we`/`addr`/`wdata` are latched in IDLE. Requester inputs are ignored outside IDLE.
- At most one `bank_cs` bit is 0 in any cycle. It is 0 only in RD_DRIVE and RD_CAPTURE.
- Outside WRITE: `bank_ce` = 0, `bank_tick` = 0, `bank_d` = 0.
- Out-of-range address (addr ≥ NrOfRegs):
  - `gnt` is still issued.
  - Write: no `bank_ce` bit set.
  - Read: no `cs` asserted, `rdata` = 0, `rvalid` still pulses.
- Arbitration when both request in IDLE: see Configuration. A single requester always wins.
- `bank_clear` = 1 while `Reset` = 0 and for exactly one cycle after `Reset` returns to 1.

## Timing
- Reset values: state IDLE; all `gnt`/`rvalid` = 0; `rdata` = 0; `bank_ce` = 0; `bank_tick` = 0; `bank_d` = 0; `bank_cs` = all ones; `bank_clear` = 1; round-robin pointer = A.
- Write: `req` seen in IDLE at cycle 0. WRITE at cycle 1 (`gnt` pulse, register loads at the end of cycle 1). IDLE at cycle 2. Throughput 1 write per 2 cycles.
- Read: `req` seen at cycle 0. `gnt` at cycle 1. Capture at cycle 2. `rvalid` + data at cycle 3. IDLE at cycle 4.
- A request still high in the IDLE cycle after its `gnt` is treated as a new transaction.
- Reset asserted mid-transaction: on the next edge, state goes to IDLE, all `cs` go high-Z, no `gnt` or `rvalid` is issued, and `rdata` is cleared.
- No combinational path from any input to any output. All outputs are registered or decoded from state registers.

## Configuration
- `REGSCHED_ROUND_ROBIN_EN` defined:
  - Simultaneous requests are granted to the port not served last. The pointer updates on every grant.
  - Guarantee: each port waits at most one foreign transaction.
- `REGSCHED_ROUND_ROBIN_EN` undefined: fixed priority, A always wins over B. The pointer logic is absent.

## Structure
- `regsched_pkg`: state enum (IDLE, WRITE, RD_DRIVE, RD_CAPTURE, RD_DONE), port index constants `PORT_A`=0 / `PORT_B`=1, one-hot decode function.
- Sub-module `regsched_arbiter`:
  - Inputs: `a_req`, `b_req`, `grant_take` strobe.
  - Outputs: `winner`, `valid`.
  - Holds the round-robin pointer under the macro.

## Test plan
- Reset low 3 cycles:
  - `bank_clear`=1 throughout, then exactly one cycle after release.
  - All `cs`=1 and all `ce`=0 during reset.
- Port A writes 0x5A to reg 3: `a_gnt` and `bank_ce`=0000_1000 and `tick`=1 and `bank_d`=0x5A all in the same cycle, then the port returns to IDLE.
- Port B reads reg 3 with a model driving 0x5A when `cs[3]`=0: `b_gnt` at +1, `cs[3]`=0 for 2 cycles, `b_rvalid` with `b_rdata`=0x5A at +3.
- A and B request simultaneously for 4 back-to-back transactions:
  - Round-robin build: grants go A, B, A, B.
  - Fixed build: grants go A, A, A, A while A holds `req`.
- Read addr 12 with NrOfRegs=8: `gnt` is issued, no `cs` goes low, `rdata`=0x00 and `rvalid` pulse at +3.
- `Reset` pulled low during RD_CAPTURE: next cycle state is IDLE, all `cs`=1, no `rvalid`, `rdata`=0.

Source files
------------

// File: rtl/register_bus_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// register_bus_scheduler_pkg
// Shared types and helpers for the register bus scheduler:
//   state_e     - scheduler FSM states
//   PORT_A/B    - requester index encoding (A = CPU core, B = display/scan)
//   MAX_REGS    - upper bound on bank size supported by the decoder
//   onehot_dec  - index -> one-hot decode; indices >= MAX_REGS decode to zero
// No ports; configuration macro REGSCHED_ROUND_ROBIN_EN is not used here.
// ----------------------------------------------------------------------------
package register_bus_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WRITE      = 3'd1,
    RD_DRIVE   = 3'd2,
    RD_CAPTURE = 3'd3,
    RD_DONE    = 3'd4
  } state_e;

  localparam logic PORT_A   = 1'b0;
  localparam logic PORT_B   = 1'b1;
  localparam int   MAX_REGS = 16;

  function automatic logic [MAX_REGS-1:0] onehot_dec(input logic [31:0] idx);
    onehot_dec = '0;
    for (int i = 0; i < MAX_REGS; i++) begin
      if (idx == 32'(i)) onehot_dec[i] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/register_bus_scheduler_if.sv
// ----------------------------------------------------------------------------
// register_bus_scheduler_if
// Bundles both requester ports and the register-bank side of the scheduler.
//   a_*/b_* req, we, addr, wdata   : requester -> scheduler
//   a_*/b_* gnt, rvalid, rdata     : scheduler -> requester
//   bank_ce, bank_tick, bank_d     : write strobes and shared D bus
//   bank_cs                        : per-register output enable (1 = high-Z)
//   bank_q                         : shared tri-state read bus (bank -> scheduler)
//   bank_clear                     : bank asynchronous clear
// Modports: slave = scheduler, master = front ends plus register bank.
// ----------------------------------------------------------------------------
interface register_bus_scheduler_if #(
  parameter int NrOfRegs = 8,
  parameter int NrOfBits = 8,
  parameter int AddrBits = 4
);
  logic                a_req,    b_req;
  logic                a_we,     b_we;
  logic [AddrBits-1:0] a_addr,   b_addr;
  logic [NrOfBits-1:0] a_wdata,  b_wdata;
  logic                a_gnt,    b_gnt;
  logic                a_rvalid, b_rvalid;
  logic [NrOfBits-1:0] a_rdata,  b_rdata;
  logic [NrOfRegs-1:0] bank_ce;
  logic                bank_tick;
  logic [NrOfBits-1:0] bank_d;
  logic [NrOfRegs-1:0] bank_cs;
  logic [NrOfBits-1:0] bank_q;
  logic                bank_clear;

  modport slave (
    input  a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, bank_q,
    output a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
           bank_ce, bank_tick, bank_d, bank_cs, bank_clear
  );

  modport master (
    output a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, bank_q,
    input  a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
           bank_ce, bank_tick, bank_d, bank_cs, bank_clear
  );
endinterface

// File: rtl/register_bus_scheduler_arbiter.sv
// ----------------------------------------------------------------------------
// register_bus_scheduler_arbiter
// Picks which requester the scheduler serves next.
//   Clock, Reset (sync, active-low), a_req, b_req, grant_take (winner accepted)
//   winner (PORT_A/PORT_B), valid (any request pending)
// REGSCHED_ROUND_ROBIN_EN defined : on a tie the port not served last wins;
//                                   the priority pointer moves on every grant.
// REGSCHED_ROUND_ROBIN_EN undefined: fixed priority, A beats B; stateless.
// ----------------------------------------------------------------------------
module register_bus_scheduler_arbiter
  import register_bus_scheduler_pkg::*;
(
  input  logic Clock,
  input  logic Reset,
  input  logic a_req,
  input  logic b_req,
  input  logic grant_take,
  output logic winner,
  output logic valid
);

  assign valid = a_req | b_req;

`ifdef REGSCHED_ROUND_ROBIN_EN
  // prio_q names the port that wins the next tie.
  logic prio_q;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      prio_q <= PORT_A;
    end else if (grant_take) begin
      prio_q <= ~winner;
    end
  end

  always_comb begin
    winner = PORT_A;
    if (a_req && b_req) winner = prio_q;
    else if (b_req)     winner = PORT_B;
  end
`else
  assign winner = (b_req && !a_req) ? PORT_B : PORT_A;

  // Fixed priority needs no state; these inputs exist for a uniform interface.
  logic unused_fixed;
  assign unused_fixed = &{1'b0, Clock, Reset, grant_take};
`endif

endmodule

// File: rtl/register_bus_scheduler.sv
// ----------------------------------------------------------------------------
// register_bus_scheduler
// Shares a bank of clock-enabled, tri-state-output registers between port A
// (CPU) and port B (display/scan). Writes take 2 cycles (IDLE, WRITE); reads
// take 4 (IDLE, RD_DRIVE, RD_CAPTURE, RD_DONE). Every output is a register.
//   Clock  : rising-edge clock
//   Reset  : synchronous, active-low
//   bus    : register_bus_scheduler_if.slave (requesters + bank side)
// Configuration macro: REGSCHED_ROUND_ROBIN_EN (round-robin tie break,
// otherwise A has fixed priority).
// ----------------------------------------------------------------------------
module register_bus_scheduler
  import register_bus_scheduler_pkg::*;
#(
  parameter int NrOfRegs = 8,
  parameter int NrOfBits = 8,
  parameter int AddrBits = 4
) (
  input logic                     Clock,
  input logic                     Reset,
  register_bus_scheduler_if.slave bus
);

  state_e              state_q;
  logic                port_q;
  logic [AddrBits-1:0] addr_q;
  logic                a_gnt_q, b_gnt_q, a_rvalid_q, b_rvalid_q;
  logic [NrOfBits-1:0] a_rdata_q, b_rdata_q;
  logic [NrOfRegs-1:0] ce_q, cs_q;
  logic                tick_q;
  logic [NrOfBits-1:0] d_q;
  logic                clear_q, hold_q;

  logic                arb_winner, arb_valid, grant_take;
  logic                sel_we;
  logic [AddrBits-1:0] sel_addr;
  logic [NrOfBits-1:0] sel_wdata;
  logic [MAX_REGS-1:0] dec_w;
  logic [NrOfRegs-1:0] sel_dec;
  logic                cap_in_range;
  logic                unused_dec;

  assign grant_take = (state_q == IDLE) && arb_valid;

  register_bus_scheduler_arbiter u_arb (
    .Clock      (Clock),
    .Reset      (Reset),
    .a_req      (bus.a_req),
    .b_req      (bus.b_req),
    .grant_take (grant_take),
    .winner     (arb_winner),
    .valid      (arb_valid)
  );

  assign sel_we    = (arb_winner == PORT_B) ? bus.b_we    : bus.a_we;
  assign sel_addr  = (arb_winner == PORT_B) ? bus.b_addr  : bus.a_addr;
  assign sel_wdata = (arb_winner == PORT_B) ? bus.b_wdata : bus.a_wdata;

  // Out-of-range indices land above bit NrOfRegs-1 (or nowhere), so the slice
  // below yields no enable and no chip-select for them.
  assign dec_w        = onehot_dec(32'(sel_addr));
  assign sel_dec      = dec_w[NrOfRegs-1:0];
  assign unused_dec   = ^dec_w;
  assign cap_in_range = 32'(addr_q) < 32'(NrOfRegs);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q    <= IDLE;
      port_q     <= PORT_A;
      addr_q     <= '0;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      ce_q       <= '0;
      tick_q     <= 1'b0;
      d_q        <= '0;
      cs_q       <= '1;
      clear_q    <= 1'b1;
      hold_q     <= 1'b1;
    end else begin
      // hold_q stretches the bank clear by one cycle past reset release.
      clear_q    <= hold_q;
      hold_q     <= 1'b0;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      ce_q       <= '0;
      tick_q     <= 1'b0;
      d_q        <= '0;
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            port_q  <= arb_winner;
            addr_q  <= sel_addr;
            a_gnt_q <= (arb_winner == PORT_A);
            b_gnt_q <= (arb_winner == PORT_B);
            if (sel_we) begin
              state_q <= WRITE;
              ce_q    <= sel_dec;
              tick_q  <= 1'b1;
              d_q     <= sel_wdata;
            end else begin
              state_q <= RD_DRIVE;
              cs_q    <= ~sel_dec;
            end
          end
        end
        WRITE:    state_q <= IDLE;
        RD_DRIVE: state_q <= RD_CAPTURE;
        RD_CAPTURE: begin
          if (port_q == PORT_A) begin
            a_rdata_q  <= cap_in_range ? bus.bank_q : '0;
            a_rvalid_q <= 1'b1;
          end else begin
            b_rdata_q  <= cap_in_range ? bus.bank_q : '0;
            b_rvalid_q <= 1'b1;
          end
          cs_q    <= '1;
          state_q <= RD_DONE;
        end
        RD_DONE:  state_q <= IDLE;
        default: begin
          state_q <= IDLE;
          cs_q    <= '1;
        end
      endcase
    end
  end

  assign bus.a_gnt      = a_gnt_q;
  assign bus.b_gnt      = b_gnt_q;
  assign bus.a_rvalid   = a_rvalid_q;
  assign bus.b_rvalid   = b_rvalid_q;
  assign bus.a_rdata    = a_rdata_q;
  assign bus.b_rdata    = b_rdata_q;
  assign bus.bank_ce    = ce_q;
  assign bus.bank_tick  = tick_q;
  assign bus.bank_d     = d_q;
  assign bus.bank_cs    = cs_q;
  assign bus.bank_clear = clear_q;

endmodule

// File: tb/tb_register_bus_scheduler.sv
// ----------------------------------------------------------------------------
// tb_register_bus_scheduler
// Directed scenarios with literal expectations, then randomized traffic on
// both ports. A transaction-level reference model (queue of per-cycle output
// records pushed when a transaction is accepted) is compared against every
// DUT output on every falling edge. A behavioural register bank drives bank_q.
// Build with REGSCHED_ROUND_ROBIN_EN to match a round-robin RTL build.
// ----------------------------------------------------------------------------
module tb_register_bus_scheduler;
  localparam int NR = 8;
  localparam int NB = 8;
  localparam int AB = 4;

  logic Clock = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  logic chk_en;

  register_bus_scheduler_if #(.NrOfRegs(NR), .NrOfBits(NB), .AddrBits(AB)) bus ();

  register_bus_scheduler #(.NrOfRegs(NR), .NrOfBits(NB), .AddrBits(AB)) dut (
    .Clock (Clock),
    .Reset (rst_n),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=0x%0h expected=0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural register bank ----------------
  logic [NB-1:0] bmem [NR];
  logic [NB-1:0] noise;

  always @(posedge Clock) begin
    for (int i = 0; i < NR; i++) begin
      if (bus.bank_clear)                       bmem[i] <= '0;
      else if (bus.bank_tick && bus.bank_ce[i]) bmem[i] <= bus.bank_d;
    end
    noise <= NB'($urandom);
  end

  always_comb begin
    bus.bank_q = noise;
    for (int i = 0; i < NR; i++) begin
      if (!bus.bank_cs[i]) bus.bank_q = bmem[i];
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic          ga, gb, rva, rvb, tick;
    logic [NR-1:0] ce, cs;
    logic [NB-1:0] d, rd;
  } rec_t;

  function automatic rec_t idle_rec();
    rec_t r;
    r.ga = 0; r.gb = 0; r.rva = 0; r.rvb = 0; r.tick = 0;
    r.ce = '0; r.cs = '1; r.d = '0; r.rd = '0;
    return r;
  endfunction

  rec_t          mq [$];
  logic [NB-1:0] m_mem [NR];
  logic          m_hold;
`ifdef REGSCHED_ROUND_ROBIN_EN
  logic          m_ptr;
`endif
  logic          e_ga, e_gb, e_rva, e_rvb, e_tick, e_clear;
  logic [NR-1:0] e_ce, e_cs;
  logic [NB-1:0] e_d, e_rda, e_rdb;

  always @(posedge Clock) begin : model
    rec_t          r, g, c, v;
    logic          w, we;
    logic [AB-1:0] addr;
    logic [NB-1:0] wd;
    logic [NR-1:0] bit1;
    int            ai;
    bit1 = 1;
    r = idle_rec();
    if (!rst_n) begin
      mq.delete();
      for (int i = 0; i < NR; i++) m_mem[i] = '0;
      e_rda = '0; e_rdb = '0; e_clear = 1; m_hold = 1;
`ifdef REGSCHED_ROUND_ROBIN_EN
      m_ptr = 0;
`endif
    end else begin
      e_clear = m_hold;
      m_hold  = 0;
      if (mq.size() == 0 && (bus.a_req || bus.b_req)) begin
        if (bus.a_req && bus.b_req) begin
`ifdef REGSCHED_ROUND_ROBIN_EN
          w = m_ptr;
`else
          w = 0;
`endif
        end else begin
          w = bus.b_req;
        end
`ifdef REGSCHED_ROUND_ROBIN_EN
        m_ptr = !w;
`endif
        we   = w ? bus.b_we    : bus.a_we;
        addr = w ? bus.b_addr  : bus.a_addr;
        wd   = w ? bus.b_wdata : bus.a_wdata;
        ai   = int'(addr);
        g = idle_rec();
        g.ga = !w; g.gb = w;
        if (we) begin
          g.ce = (ai < NR) ? (bit1 << addr) : '0;
          g.tick = 1; g.d = wd;
          if (ai < NR) m_mem[ai] = wd;
          mq.push_back(g);
          mq.push_back(idle_rec());
        end else begin
          g.cs = (ai < NR) ? ~(bit1 << addr) : '1;
          mq.push_back(g);
          c = idle_rec(); c.cs = g.cs;
          mq.push_back(c);
          v = idle_rec(); v.rva = !w; v.rvb = w;
          v.rd = (ai < NR) ? m_mem[ai] : '0;
          mq.push_back(v);
          mq.push_back(idle_rec());
        end
      end
      if (mq.size() != 0) r = mq.pop_front();
      if (r.rva) e_rda = r.rd;
      if (r.rvb) e_rdb = r.rd;
    end
    e_ga = r.ga; e_gb = r.gb; e_rva = r.rva; e_rvb = r.rvb;
    e_tick = r.tick; e_ce = r.ce; e_cs = r.cs; e_d = r.d;
  end

  always @(negedge Clock) begin
    if (chk_en) begin
      check("a_gnt",      bus.a_gnt,      e_ga);
      check("b_gnt",      bus.b_gnt,      e_gb);
      check("a_rvalid",   bus.a_rvalid,   e_rva);
      check("b_rvalid",   bus.b_rvalid,   e_rvb);
      check("a_rdata",    bus.a_rdata,    e_rda);
      check("b_rdata",    bus.b_rdata,    e_rdb);
      check("bank_ce",    bus.bank_ce,    e_ce);
      check("bank_tick",  bus.bank_tick,  e_tick);
      check("bank_d",     bus.bank_d,     e_d);
      check("bank_cs",    bus.bank_cs,    e_cs);
      check("bank_clear", bus.bank_clear, e_clear);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int p, input logic req, input logic we,
                       input logic [AB-1:0] addr, input logic [NB-1:0] wd);
    if (p == 0) begin
      bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
    end else begin
      bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
    end
  endtask

  task automatic set_req(input int p, input logic v);
    if (p == 0) bus.a_req = v; else bus.b_req = v;
  endtask

  function automatic logic gnt_of(input int p);
    return (p == 0) ? bus.a_gnt : bus.b_gnt;
  endfunction

  function automatic logic req_of(input int p);
    return (p == 0) ? bus.a_req : bus.b_req;
  endfunction

  task automatic do_write(input int p, input logic [AB-1:0] addr,
                          input logic [NB-1:0] wd, input logic [NR-1:0] exp_ce);
    drive(p, 1, 1, addr, wd);
    @(negedge Clock);
    check("wr_gnt",  gnt_of(p),     1);
    check("wr_ce",   bus.bank_ce,   exp_ce);
    check("wr_tick", bus.bank_tick, 1);
    check("wr_d",    bus.bank_d,    wd);
    set_req(p, 0);
    @(negedge Clock);
    check("wr_ce_off",   bus.bank_ce,   0);
    check("wr_tick_off", bus.bank_tick, 0);
  endtask

  task automatic do_read(input int p, input logic [AB-1:0] addr,
                         input logic [NB-1:0] exp_rd, input logic [NR-1:0] exp_cs);
    drive(p, 1, 0, addr, '0);
    @(negedge Clock);
    check("rd_gnt", gnt_of(p), 1);
    check("rd_cs_drive", bus.bank_cs, exp_cs);
    set_req(p, 0);
    @(negedge Clock);
    check("rd_cs_capture", bus.bank_cs, exp_cs);
    check("rd_early_rvalid", (p == 0) ? bus.a_rvalid : bus.b_rvalid, 0);
    @(negedge Clock);
    check("rd_rvalid", (p == 0) ? bus.a_rvalid : bus.b_rvalid, 1);
    check("rd_rdata",  (p == 0) ? bus.a_rdata  : bus.b_rdata,  exp_rd);
    check("rd_cs_done", bus.bank_cs, 8'hFF);
    @(negedge Clock);
    check("rd_rvalid_off", (p == 0) ? bus.a_rvalid : bus.b_rvalid, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int exp_w [4];
    int got, n, rst_cnt;
    chk_en = 0;
    rst_n  = 0;
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
`ifdef REGSCHED_ROUND_ROBIN_EN
    exp_w = '{0, 1, 0, 1};
`else
    exp_w = '{0, 0, 0, 0};
`endif
    @(posedge Clock);
    #1 chk_en = 1;

    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      check("rst_clear", bus.bank_clear, 1);
      check("rst_cs",    bus.bank_cs,    8'hFF);
      check("rst_ce",    bus.bank_ce,    0);
      check("rst_gnt",   {bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid}, 0);
    end
    rst_n = 1;
    @(negedge Clock);
    check("clear_hold", bus.bank_clear, 1);
    @(negedge Clock);
    check("clear_drop", bus.bank_clear, 0);

    do_write(0, 4'd3, 8'h5A, 8'b0000_1000);
    do_read (1, 4'd3, 8'h5A, 8'b1111_0111);
    do_read (0, 4'd3, 8'h5A, 8'b1111_0111);
    do_read (0, 4'd12, 8'h00, 8'hFF);
    do_write(1, 4'd5, 8'hC3, 8'b0010_0000);
    do_write(0, 4'd9, 8'h77, 8'b0000_0000);
    do_read (1, 4'd5, 8'hC3, 8'b1101_1111);

    // Both ports request writes continuously; record the grant order.
    drive(0, 1, 1, 4'd1, 8'h11);
    drive(1, 1, 1, 4'd2, 8'h22);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(negedge Clock);
        n++;
      end while (!bus.a_gnt && !bus.b_gnt && n < 10);
      got = bus.a_gnt ? 0 : (bus.b_gnt ? 1 : 2);
      check("arb_order", got, exp_w[k]);
      if (got == 0) bus.a_wdata = bus.a_wdata + 8'h10;
      if (got == 1) bus.b_wdata = bus.b_wdata + 8'h10;
    end
    set_req(0, 0);
    set_req(1, 0);
    repeat (4) @(negedge Clock);

    // Reset lands while the read sits in RD_CAPTURE.
    drive(1, 1, 0, 4'd3, '0);
    @(negedge Clock);
    check("rc_gnt", bus.b_gnt, 1);
    set_req(1, 0);
    @(negedge Clock);
    check("rc_cs_low", bus.bank_cs, 8'b1111_0111);
    rst_n = 0;
    @(negedge Clock);
    check("rc_cs",     bus.bank_cs,  8'hFF);
    check("rc_rvalid", bus.b_rvalid, 0);
    check("rc_rdata",  bus.b_rdata,  0);
    check("rc_ardata", bus.a_rdata,  0);
    rst_n = 1;
    repeat (3) @(negedge Clock);

    // Randomized traffic, with occasional resets (requests held low around them).
    rst_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge Clock);
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 2) rst_n = 1;
      end else if ($urandom_range(0, 299) == 0) begin
        rst_n = 0;
        set_req(0, 0);
        set_req(1, 0);
        rst_cnt = 4;
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (req_of(p) && gnt_of(p)) begin
            if ($urandom_range(0, 1) == 1)
              drive(p, 1, 1'($urandom), AB'($urandom_range(0, 15)), NB'($urandom));
            else
              set_req(p, 0);
          end else if (!req_of(p) && $urandom_range(0, 2) == 0) begin
            drive(p, 1, 1'($urandom), AB'($urandom_range(0, 15)), NB'($urandom));
          end
        end
      end
    end
    set_req(0, 0);
    set_req(1, 0);
    repeat (6) @(negedge Clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
